// File: rtl/data_mem_responder_if.sv
// Data-memory bus between the core (master) and the memory responder (slave),
// plus the debug read port used to dump memory contents.
interface data_mem_responder_if #(
    parameter int DEPTH = 48
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [31:0]      offset;
    logic             mem_cen;
    logic             mem_wen;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;
    logic             mem_ready;
    logic             mem_stall;
    logic             mem_err;
    logic [IDX_W-1:0] dbg_idx;
    logic [31:0]      dbg_data;

    modport master (
        output offset, mem_cen, mem_wen, mem_addr, mem_wdata, dbg_idx,
        input  mem_rdata, mem_ready, mem_stall, mem_err, dbg_data
    );

    modport slave (
        input  offset, mem_cen, mem_wen, mem_addr, mem_wdata, dbg_idx,
        output mem_rdata, mem_ready, mem_stall, mem_err, dbg_data
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a fixed number of wait states per access;
// stalls the core from request until the registered one-cycle ready pulse.
module data_mem_responder #(
    parameter int DEPTH   = 48,
    parameter int LATENCY = 2
) (
    input  logic clk,
    input  logic rst,
    data_mem_responder_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] offset_q, offset_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wen_q, wen_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH];

    logic [29:0]      wordDiff;
    logic [IDX_W-1:0] idx;
    logic             valid;
    logic             doAccess;

    // Range check works only on the latched request; the subtraction wraps on purpose.
    assign wordDiff = 30'((addr_q - offset_q) >> 2);
    assign idx      = wordDiff[IDX_W-1:0];
    assign valid    = (addr_q >= offset_q) && (addr_q[1:0] == 2'b00) && (wordDiff < 30'(DEPTH));
    assign doAccess = (state_q == WAIT) && (cnt_q == 4'd1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        offset_d = offset_q;
        wdata_d  = wdata_q;
        wen_d    = wen_q;
        rdata_d  = rdata_q;
        ready_d  = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.mem_cen) begin
                    addr_d   = bus.mem_addr;
                    offset_d = bus.offset;
                    wdata_d  = bus.mem_wdata;
                    wen_d    = bus.mem_wen;
                    cnt_d    = 4'(LATENCY);
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    err_d   = ~valid;
                    if (!wen_q) begin
                        rdata_d = valid ? mem_q[idx] : 32'h0;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= 32'h0;
            offset_q <= 32'h0;
            wdata_q  <= 32'h0;
            wen_q    <= 1'b0;
            rdata_q  <= 32'h0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            offset_q <= offset_d;
            wdata_q  <= wdata_d;
            wen_q    <= wen_d;
            rdata_q  <= rdata_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
        end
    end

    // Contents survive reset, but a reset edge still cancels a pending write.
    always_ff @(posedge clk) begin
        if (!rst && doAccess && wen_q && valid) begin
            mem_q[idx] <= wdata_q;
        end
    end

    assign bus.mem_rdata = rdata_q;
    assign bus.mem_ready = ready_q;
    assign bus.mem_err   = err_q;
    assign bus.mem_stall = bus.mem_cen & ~ready_q;
    assign bus.dbg_data  = (int'(bus.dbg_idx) < DEPTH) ? mem_q[bus.dbg_idx] : 32'h0;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: latency/stall timing, address checks,
// input latching, reset during an access and back-to-back traffic at LATENCY=1.
module tb_data_mem_responder;
    localparam logic [31:0] OFF = 32'h10010000;

    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    logic [31:0] model [48];

    always #5 clk = ~clk;

    data_mem_responder_if #(.DEPTH(48)) bus ();
    data_mem_responder_if #(.DEPTH(48)) bus2 ();

    data_mem_responder #(.DEPTH(48), .LATENCY(2)) dut (.clk(clk), .rst(rst), .bus(bus));
    data_mem_responder #(.DEPTH(48), .LATENCY(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Runs one access on bus; returns the cycle ready was seen (-1 on timeout).
    task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         output int rc, output logic [31:0] rd, output logic er, output bit stallOk);
        rc = -1;
        rd = 32'h0;
        er = 1'b0;
        stallOk = 1'b1;
        bus.mem_cen   = 1'b1;
        bus.mem_wen   = wen;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (bus.mem_ready === 1'b1) begin
                rc = c;
                rd = bus.mem_rdata;
                er = bus.mem_err;
                if (bus.mem_stall !== 1'b0) stallOk = 1'b0;
                break;
            end else if (bus.mem_stall !== 1'b1) begin
                stallOk = 1'b0;
            end
            sync();
        end
        bus.mem_cen = 1'b0;
        sync();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.offset = OFF;   bus.mem_cen = 1'b0;  bus.mem_wen = 1'b0;
        bus.mem_addr = 32'h0; bus.mem_wdata = 32'h0; bus.dbg_idx = '0;
        bus2.offset = 32'h0; bus2.mem_cen = 1'b0; bus2.mem_wen = 1'b0;
        bus2.mem_addr = 32'h0; bus2.mem_wdata = 32'h0; bus2.dbg_idx = '0;
        repeat (2) sync();
        checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", bus.mem_ready); end
        checks++; if (bus.mem_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", bus.mem_err); end
        checks++; if (bus.mem_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 00000000", bus.mem_rdata); end
        checks++; if (bus.mem_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall_idle: got %b expected 0", bus.mem_stall); end
        bus.mem_cen = 1'b1;
        #1;
        checks++; if (bus.mem_stall !== 1'b1) begin errors++; $display("[TB] FAIL reset_stall_cen: got %b expected 1", bus.mem_stall); end
        sync();
        bus.mem_cen = 1'b0;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            sync();
            checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_no_accept: got %b expected 0 (cycle %0d)", bus.mem_ready, c); end
        end
    endtask

    task automatic preload();
        int rc; logic [31:0] rd; logic er; bit so;
        for (int i = 0; i < 48; i++) begin
            model[i] = 32'hA5000000 | 32'(i);
            issue(1'b1, OFF + 32'(4 * i), model[i], rc, rd, er, so);
        end
    endtask

    task automatic test_write_latency();
        int rc; logic [31:0] rd; logic er; bit so;
        issue(1'b1, OFF + 32'h8, 32'hDEADBEEF, rc, rd, er, so);
        model[2] = 32'hDEADBEEF;
        checks++; if (rc !== 3) begin errors++; $display("[TB] FAIL write_ready_cycle: got %0d expected 3", rc); end
        checks++; if (so !== 1'b1) begin errors++; $display("[TB] FAIL write_stall_pattern: got %b expected 1", so); end
        checks++; if (er !== 1'b0) begin errors++; $display("[TB] FAIL write_err: got %b expected 0", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL write_keeps_rdata: got %h expected 00000000", rd); end
        bus.dbg_idx = 6'd2;
        #1;
        checks++; if (bus.dbg_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL write_mem2: got %h expected deadbeef", bus.dbg_data); end
        sync();
    endtask

    task automatic test_read();
        int rc; logic [31:0] rd; logic er; bit so;
        issue(1'b0, OFF + 32'h8, 32'h0, rc, rd, er, so);
        checks++; if (rc !== 3) begin errors++; $display("[TB] FAIL read_ready_cycle: got %0d expected 3", rc); end
        checks++; if (so !== 1'b1) begin errors++; $display("[TB] FAIL read_stall_pattern: got %b expected 1", so); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL read_data: got %h expected deadbeef", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("[TB] FAIL read_err: got %b expected 0", er); end
        checks++; if (bus.mem_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL read_hold: got %h expected deadbeef", bus.mem_rdata); end
        checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("[TB] FAIL read_ready_one_cycle: got %b expected 0", bus.mem_ready); end
    endtask

    task automatic test_invalid();
        int rc; logic [31:0] rd; logic er; bit so;
        issue(1'b0, 32'h1001000A, 32'h0, rc, rd, er, so);
        checks++; if (rd !== 32'h0 || er !== 1'b1) begin errors++; $display("[TB] FAIL misaligned_read: got data %h err %b expected 00000000 1", rd, er); end
        checks++; if (rc !== 3) begin errors++; $display("[TB] FAIL misaligned_ready_cycle: got %0d expected 3", rc); end
        issue(1'b0, OFF + 32'd192, 32'h0, rc, rd, er, so);
        checks++; if (rd !== 32'h0 || er !== 1'b1) begin errors++; $display("[TB] FAIL range_read: got data %h err %b expected 00000000 1", rd, er); end
        issue(1'b0, OFF - 32'd4, 32'h0, rc, rd, er, so);
        checks++; if (rd !== 32'h0 || er !== 1'b1) begin errors++; $display("[TB] FAIL below_offset_read: got data %h err %b expected 00000000 1", rd, er); end
        issue(1'b0, OFF + 32'd188, 32'h0, rc, rd, er, so);
        checks++; if (rd !== 32'hA500002F || er !== 1'b0) begin errors++; $display("[TB] FAIL last_word_read: got data %h err %b expected a500002f 0", rd, er); end
        issue(1'b1, OFF + 32'd192, 32'hBAD0BAD0, rc, rd, er, so);
        checks++; if (er !== 1'b1) begin errors++; $display("[TB] FAIL range_write_err: got %b expected 1", er); end
        for (int i = 0; i < 48; i++) begin
            bus.dbg_idx = 6'(i);
            #1;
            checks++; if (bus.dbg_data !== model[i]) begin errors++; $display("[TB] FAIL range_write_mem%0d: got %h expected %h", i, bus.dbg_data, model[i]); end
        end
        bus.dbg_idx = 6'd50;
        #1;
        checks++; if (bus.dbg_data !== 32'h0) begin errors++; $display("[TB] FAIL dbg_out_of_range: got %h expected 00000000", bus.dbg_data); end
        sync();
    endtask

    task automatic test_wait_ignore();
        int rc = -1;
        bus.mem_cen = 1'b1; bus.mem_wen = 1'b1;
        bus.mem_addr = OFF + 32'd20; bus.mem_wdata = 32'h11111111;
        sync();
        bus.mem_addr = OFF + 32'd24; bus.mem_wdata = 32'h22222222;
        for (int c = 1; c < 12; c++) begin
            #1;
            if (bus.mem_ready === 1'b1) begin rc = c; break; end
            sync();
        end
        bus.mem_cen = 1'b0;
        model[5] = 32'h11111111;
        checks++; if (rc !== 3) begin errors++; $display("[TB] FAIL latch_ready_cycle: got %0d expected 3", rc); end
        sync();
        bus.dbg_idx = 6'd5;
        #1;
        checks++; if (bus.dbg_data !== 32'h11111111) begin errors++; $display("[TB] FAIL latch_mem5: got %h expected 11111111", bus.dbg_data); end
        bus.dbg_idx = 6'd6;
        #1;
        checks++; if (bus.dbg_data !== model[6]) begin errors++; $display("[TB] FAIL latch_mem6: got %h expected %h", bus.dbg_data, model[6]); end
        sync();
    endtask

    task automatic test_reset_mid();
        int rc; logic [31:0] rd; logic er; bit so;
        bit sawReady = 1'b0;
        bus.mem_cen = 1'b1; bus.mem_wen = 1'b1;
        bus.mem_addr = OFF + 32'd28; bus.mem_wdata = 32'h77777777;
        sync();
        sync();
        rst = 1'b1;
        bus.mem_cen = 1'b0;
        sync();
        rst = 1'b0;
        checks++; if (bus.mem_rdata !== 32'h0) begin errors++; $display("[TB] FAIL midreset_rdata: got %h expected 00000000", bus.mem_rdata); end
        for (int c = 0; c < 5; c++) begin
            #1;
            if (bus.mem_ready !== 1'b0) sawReady = 1'b1;
            sync();
        end
        checks++; if (sawReady !== 1'b0) begin errors++; $display("[TB] FAIL midreset_ready: got %b expected 0", sawReady); end
        bus.dbg_idx = 6'd7;
        #1;
        checks++; if (bus.dbg_data !== model[7]) begin errors++; $display("[TB] FAIL midreset_mem7: got %h expected %h", bus.dbg_data, model[7]); end
        sync();
        issue(1'b0, OFF + 32'd28, 32'h0, rc, rd, er, so);
        checks++; if (rc !== 3) begin errors++; $display("[TB] FAIL midreset_next_cycle: got %0d expected 3", rc); end
        checks++; if (rd !== model[7] || er !== 1'b0) begin errors++; $display("[TB] FAIL midreset_next_read: got data %h err %b expected %h 0", rd, er, model[7]); end
    endtask

    task automatic test_back_to_back();
        logic        reqWen   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] reqAddr  [4] = '{32'h0, 32'h4, 32'h8, 32'h8};
        logic [31:0] reqWdata [4] = '{32'h600D0000, 32'h600D0001, 32'h600D0002, 32'h0};
        int k;
        sync();
        bus2.mem_cen = 1'b1;
        bus2.mem_wen = reqWen[0]; bus2.mem_addr = reqAddr[0]; bus2.mem_wdata = reqWdata[0];
        for (int c = 0; c < 12; c++) begin
            #1;
            checks++; if (bus2.mem_ready !== ((c % 3) == 2)) begin errors++; $display("[TB] FAIL b2b_ready: got %b expected %b (cycle %0d)", bus2.mem_ready, (c % 3) == 2, c); end
            checks++; if (bus2.mem_stall !== ((c % 3) != 2)) begin errors++; $display("[TB] FAIL b2b_stall: got %b expected %b (cycle %0d)", bus2.mem_stall, (c % 3) != 2, c); end
            if ((c % 3) == 2) begin
                k = c / 3 + 1;
                if (c == 11) begin
                    checks++; if (bus2.mem_rdata !== 32'h600D0002) begin errors++; $display("[TB] FAIL b2b_read: got %h expected 600d0002", bus2.mem_rdata); end
                end
                if (k < 4) begin
                    bus2.mem_wen = reqWen[k]; bus2.mem_addr = reqAddr[k]; bus2.mem_wdata = reqWdata[k];
                end else begin
                    bus2.mem_cen = 1'b0;
                end
            end
            sync();
        end
        bus2.dbg_idx = 6'd2;
        #1;
        checks++; if (bus2.dbg_data !== 32'h600D0002) begin errors++; $display("[TB] FAIL b2b_dbg2: got %h expected 600d0002", bus2.dbg_data); end
        bus2.dbg_idx = 6'd0;
        #1;
        checks++; if (bus2.dbg_data !== 32'h600D0000) begin errors++; $display("[TB] FAIL b2b_dbg0: got %h expected 600d0000", bus2.dbg_data); end
        sync();
    endtask

    initial begin
        test_reset();
        preload();
        test_write_latency();
        test_read();
        test_invalid();
        test_wait_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end
endmodule
